// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the fetch stage.
//   XLEN       - architectural address/instruction width
//   INSTR_NOP  - canonical NOP encoding (addi x0, x0, 0)
//   PC_STEP    - byte distance between sequential instructions
//   fetch_entry_t - one buffered fetch result, laid out {pc, instr}
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush.
//   clk, reset_n   - clock, asynchronous active-low reset (control state only)
//   flush          - empties the FIFO; overrides push and pop in that cycle
//   push/push_data - write request and data; accepted when not full or when
//                    a pop happens in the same cycle
//   pop/pop_data   - read request; pop_data is the current head (show-ahead)
//   empty/full     - occupancy flags
//   count          - number of stored entries
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Explicit wrap so that non-power-of-two depths also work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage wrapped around an external pc register.
//   clk, reset_n                 - clock, asynchronous active-low reset
//   current_pc / next_pc         - pc register output / input (next_pc is comb)
//   imem_req/addr/gnt            - in-order request channel to instruction memory
//   imem_rvalid/rdata            - in-order, variable-latency response channel
//   redirect_valid/redirect_pc   - taken branch/jump from execute
//   if_valid/if_ready            - handshake towards decode
//   if_instr/if_pc               - head of the output buffer (zero when empty)
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FIFO_DEPTH   = 2,
  parameter int              MAX_OUTST    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] current_pc,
  output logic [XLEN-1:0] next_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc
);

  import cpu_pkg::*;

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);

  logic [OW-1:0]     r_outst;
  logic [OW-1:0]     r_discard;
  logic              w_fire;
  logic              w_rsp;
  logic              w_drop;
  logic              w_credit_ok;
  logic [XLEN-1:0]   w_pend_pc;
  logic              w_pend_empty;
  logic              w_pend_full;
  logic [OW-1:0]     w_pend_count;
  logic              w_out_push;
  logic              w_out_pop;
  logic              w_out_empty;
  logic              w_out_full;
  logic [FW-1:0]     w_out_count;
  logic [2*XLEN-1:0] w_out_head;

  assign imem_addr = current_pc & ~XLEN'(3);

  // Every granted request and every buffered word owns one output slot, except
  // the words already condemned by a redirect. A slot being read by decode this
  // cycle counts as free, which is what sustains one instruction per clock.
  assign w_credit_ok = (32'(w_out_count) - 32'(w_out_pop) + 32'(r_outst)
                        - 32'(r_discard)) < 32'(FIFO_DEPTH);

  assign imem_req = reset_n && !redirect_valid
                    && (r_outst < OW'(MAX_OUTST)) && w_credit_ok;
  assign w_fire   = imem_req && imem_gnt;

  // A response with nothing in flight is a protocol error and is ignored.
  assign w_rsp      = imem_rvalid && (r_outst != '0);
  assign w_drop     = w_rsp && (r_discard != '0);
  assign w_out_push = w_rsp && !w_drop && !redirect_valid;
  assign w_out_pop  = if_valid && if_ready;

  always_comb begin
    next_pc = current_pc;
    if (!reset_n)            next_pc = RESET_VECTOR;
    else if (redirect_valid) next_pc = redirect_pc & ~XLEN'(3);
    else if (w_fire)         next_pc = current_pc + XLEN'(PC_STEP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outst   <= '0;
      r_discard <= '0;
    end else begin
      r_outst <= r_outst + OW'(w_fire) - OW'(w_rsp);
      // On redirect everything still in flight after this cycle is stale.
      // No request fires in a redirect cycle, so that is outst minus any
      // response retired now.
      if (redirect_valid) r_discard <= r_outst - OW'(w_rsp);
      else                r_discard <= r_discard - OW'(w_drop);
    end
  end

  // Pending-pc queue: pc of every granted request, popped by its response.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pend_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (1'b0),
    .push      (w_fire),
    .push_data (imem_addr),
    .pop       (w_rsp),
    .pop_data  (w_pend_pc),
    .empty     (w_pend_empty),
    .full      (w_pend_full),
    .count     (w_pend_count)
  );

  // Output buffer of {pc, instr} towards decode; flushed by a redirect.
  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_out_q (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (redirect_valid),
    .push      (w_out_push),
    .push_data ({w_pend_pc, imem_rdata}),
    .pop       (w_out_pop),
    .pop_data  (w_out_head),
    .empty     (w_out_empty),
    .full      (w_out_full),
    .count     (w_out_count)
  );

  assign if_valid = !w_out_empty;
  assign if_pc    = if_valid ? w_out_head[2*XLEN-1:XLEN] : '0;
  assign if_instr = if_valid ? w_out_head[XLEN-1:0]      : '0;

  a_rvalid_without_request: assert property (@(posedge clk) disable iff (!reset_n)
    !(imem_rvalid && r_outst == '0))
    else $error("imem_rvalid with no outstanding request");

  a_pending_tracks_outst: assert property (@(posedge clk) disable iff (!reset_n)
    (w_pend_count == r_outst) && !(w_rsp && w_pend_empty) && !(w_fire && w_pend_full));

  a_no_output_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_out_push && w_out_full && !w_out_pop));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] current_pc;
  logic [31:0] next_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int checks   = 0;
  int failures = 0;

  // Memory model and delivery logs.
  logic [31:0] mem_q[$];
  logic [31:0] fired[$];
  logic [31:0] dl_pc[$];
  logic [31:0] dl_instr[$];
  int          dl_cyc[$];
  bit          rsp_en;
  int          cyc;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(2), .MAX_OUTST(2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .current_pc     (current_pc),
    .next_pc        (next_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  function automatic logic [31:0] dlp(input int i);
    return (i < dl_pc.size()) ? dl_pc[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dli(input int i);
    return (i < dl_instr.size()) ? dl_instr[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] dlc(input int i);
    return (i < dl_cyc.size()) ? 32'(dl_cyc[i]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] frd(input int i);
    return (i < fired.size()) ? fired[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_logs();
    fired.delete();
    dl_pc.delete();
    dl_instr.delete();
    dl_cyc.delete();
  endtask

  // One clock: sample handshakes just before the edge, then play pc register
  // and memory just after it.
  task automatic tick();
    logic        f, r, d;
    logic [31:0] a, np, p, ins;
    #1;
    f   = imem_req && imem_gnt;
    r   = imem_rvalid;
    a   = imem_addr;
    np  = next_pc;
    d   = if_valid && if_ready;
    p   = if_pc;
    ins = if_instr;
    if (d) begin
      dl_pc.push_back(p);
      dl_instr.push_back(ins);
      dl_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    current_pc = np;
    if (r && mem_q.size() > 0) void'(mem_q.pop_front());
    if (f) begin
      mem_q.push_back(a);
      fired.push_back(a);
    end
    if (rsp_en && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    rsp_en         = 1'b1;
    mem_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    clear_logs();
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    current_pc     = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;
    rsp_en         = 1'b1;
    cyc            = 0;

    // Reset state, then release with memory not granting.
    #1;
    check("rst_req",     32'(imem_req), 32'h0);
    check("rst_valid",   32'(if_valid), 32'h0);
    check("rst_next_pc", next_pc,       32'h0);
    check("rst_if_pc",   if_pc,         32'h0);
    do_reset();
    #1;
    check("rel_req",   32'(imem_req), 32'h1);
    check("rel_addr",  imem_addr,     32'h0);
    check("rel_valid", 32'(if_valid), 32'h0);

    // Zero-wait memory, decode always ready: one instruction per clock.
    imem_gnt = 1'b1;
    if_ready = 1'b1;
    repeat (8) tick();
    check("stream_pc0",   dlp(0), 32'h0);
    check("stream_pc1",   dlp(1), 32'h4);
    check("stream_pc2",   dlp(2), 32'h8);
    check("stream_pc3",   dlp(3), 32'hC);
    check("stream_cyc0",  dlc(0), 32'd2);
    check("stream_cyc3",  dlc(3), 32'd5);
    check("stream_instr", dli(2), 32'h0000_0813);

    // Decode stalls: buffer fills, fetch stops with pc held at 0x8.
    do_reset();
    imem_gnt = 1'b1;
    if_ready = 1'b0;
    repeat (6) tick();
    check("stall_req",     32'(imem_req),      32'h0);
    check("stall_next_pc", next_pc,            32'h8);
    check("stall_valid",   32'(if_valid),      32'h1);
    check("stall_head",    if_pc,              32'h0);
    check("stall_nodeliv", 32'(dl_pc.size()),  32'h0);
    if_ready = 1'b1;
    repeat (8) tick();
    check("drain_pc0",   dlp(0), 32'h0);
    check("drain_pc1",   dlp(1), 32'h4);
    check("drain_pc2",   dlp(2), 32'h8);
    check("drain_pc3",   dlp(3), 32'hC);
    check("drain_instr", dli(1), 32'h0000_0413);
    check("drain_fire2", frd(2), 32'h8);
    check("drain_fire3", frd(3), 32'hC);

    // Grant withheld for three clocks: address and pc hold at 0x4.
    do_reset();
    imem_gnt = 1'b1;
    if_ready = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nogt_req",     32'(imem_req), 32'h1);
      check("nogt_addr",    imem_addr,     32'h4);
      check("nogt_next_pc", next_pc,       32'h4);
      tick();
    end
    imem_gnt = 1'b1;
    repeat (6) tick();
    check("nogt_fire1", frd(1), 32'h4);
    check("nogt_fire2", frd(2), 32'h8);
    check("nogt_pc1",   dlp(1), 32'h4);
    check("nogt_pc2",   dlp(2), 32'h8);

    // Redirect to 0xA1 with two requests outstanding.
    do_reset();
    imem_gnt = 1'b1;
    if_ready = 1'b1;
    rsp_en   = 1'b0;
    repeat (2) tick();
    #1;
    check("redir_full_req", 32'(imem_req), 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_00A1;
    rsp_en         = 1'b1;
    #1;
    check("redir_next_pc", next_pc,       32'hA0);
    check("redir_req",     32'(imem_req), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_empty", 32'(if_valid), 32'h0);
    repeat (8) tick();
    check("redir_pc0",   dlp(0), 32'hA0);
    check("redir_instr", dli(0), 32'h0000_A013);
    check("redir_pc1",   dlp(1), 32'hA4);

    // Redirect with a full buffer and a same-cycle pop.
    do_reset();
    imem_gnt = 1'b1;
    if_ready = 1'b0;
    repeat (5) tick();
    check("flush_pre", 32'(if_valid), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    if_ready       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    #1;
    check("flush_empty", 32'(if_valid), 32'h0);
    repeat (8) tick();
    check("flush_pc0", dlp(0), 32'h100);
    check("flush_pc1", dlp(1), 32'h104);

    // Asynchronous reset with one buffered word and one request in flight.
    do_reset();
    imem_gnt = 1'b1;
    if_ready = 1'b0;
    tick();
    rsp_en = 1'b0;
    tick();
    #1;
    check("arst_pre", 32'(if_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    check("arst_valid",   32'(if_valid), 32'h0);
    check("arst_req",     32'(imem_req), 32'h0);
    check("arst_next_pc", next_pc,       32'h0);
    check("arst_if_pc",   if_pc,         32'h0);
    check("arst_instr",   if_instr,      32'h0);
    do_reset();
    imem_gnt = 1'b1;
    if_ready = 1'b1;
    repeat (6) tick();
    check("arst_restart", dlp(0), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
